// File: rtl/bus_periph_responder.sv
// rtl/bus_periph_responder.sv - memory-mapped LED/switch/button/7-seg/timer responder
module bus_periph_responder #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_F000,
  parameter int          SCAN_DIV  = 50000,
  parameter int          TIMER_DIV = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  input  logic [31:0] Bus_addr,
  input  logic [3:0]  Bus_we,
  input  logic [31:0] Bus_wdata,
  output logic [31:0] Bus_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  button,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PSW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [9:0] OFS_DIG   = 10'h000;
  localparam logic [9:0] OFS_TIMER = 10'h008;
  localparam logic [9:0] OFS_LED   = 10'h018;
  localparam logic [9:0] OFS_SW    = 10'h01C;
  localparam logic [9:0] OFS_BTN   = 10'h01E;

  typedef enum logic [2:0] {
    DIGIT0, DIGIT1, DIGIT2, DIGIT3, DIGIT4, DIGIT5, DIGIT6, DIGIT7
  } scan_state_t;

  scan_state_t state, state_next;

  logic [31:0]    dig_reg;
  logic [31:0]    timer;
  logic [PSW-1:0] presc;
  logic [SCW-1:0] scan_cnt;
  logic [23:0]    sw_meta, sw_sync;
  logic [4:0]     btn_meta, btn_sync;

  logic        hit, wr;
  logic [9:0]  word_ofs;
  logic        presc_wrap, scan_wrap;
  logic [31:0] dig_merged, timer_merged, led_merged;
  logic [3:0]  nibble;

  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  we);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = we[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F; 4'h1: hex7 = 7'h06; 4'h2: hex7 = 7'h5B; 4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66; 4'h5: hex7 = 7'h6D; 4'h6: hex7 = 7'h7D; 4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h6F; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39; 4'hD: hex7 = 7'h5E; 4'hE: hex7 = 7'h79; default: hex7 = 7'h71;
    endcase
  endfunction

  assign hit          = (Bus_addr[31:12] == BASE_ADDR[31:12]);
  assign word_ofs     = Bus_addr[11:2];
  assign wr           = hit && (Bus_we != 4'b0000);
  assign presc_wrap   = (presc == PSW'(TIMER_DIV - 1));
  assign scan_wrap    = (scan_cnt == SCW'(SCAN_DIV - 1));
  assign dig_merged   = byte_merge(dig_reg, Bus_wdata, Bus_we);
  assign timer_merged = byte_merge(timer, Bus_wdata, Bus_we);
  assign led_merged   = byte_merge({8'h00, led}, Bus_wdata, {1'b0, Bus_we[2:0]});

  // Zero-wait read mux; anything outside the window or unmapped reads as 0
  always_comb begin
    Bus_rdata = 32'h0;
    if (hit) begin
      case (word_ofs)
        OFS_DIG:   Bus_rdata = dig_reg;
        OFS_TIMER: Bus_rdata = timer;
        OFS_LED:   Bus_rdata = {8'h00, led};
        OFS_SW:    Bus_rdata = {8'h00, sw_sync};
        OFS_BTN:   Bus_rdata = {27'h0, btn_sync};
        default:   Bus_rdata = 32'h0;
      endcase
    end
  end

  // Writable registers with per-lane byte enables
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dig_reg <= 32'h0;
      led     <= 24'h0;
    end else if (wr) begin
      if (word_ofs == OFS_DIG) dig_reg <= dig_merged;
      if (word_ofs == OFS_LED) led     <= led_merged[23:0];
    end
  end

  // Free-running timer; a bus write overrides a coincident increment
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      timer <= 32'h0;
      presc <= '0;
    end else if (wr && (word_ofs == OFS_TIMER)) begin
      timer <= timer_merged;
      presc <= '0;
    end else if (presc_wrap) begin
      timer <= timer + 32'd1;
      presc <= '0;
    end else begin
      presc <= presc + PSW'(1);
    end
  end

  // Two-flop synchronisers for the asynchronous switch and button inputs
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      sw_meta  <= 24'h0;
      sw_sync  <= 24'h0;
      btn_meta <= 5'h0;
      btn_sync <= 5'h0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

  // Scan FSM state and per-digit dwell counter
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state    <= DIGIT0;
      scan_cnt <= '0;
    end else begin
      state    <= state_next;
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SCW'(1);
    end
  end

  // Next digit on dwell wrap; drive the selected digit's enable and segments
  always_comb begin
    state_next = state;
    nibble     = dig_reg[4*state +: 4];
    dig_en     = ~(8'b1 << state);
    dig_seg    = {1'b0, hex7(nibble)};
    if (scan_wrap) state_next = scan_state_t'(state + 3'd1);
  end

endmodule

// File: tb/tb_bus_periph_responder.sv
// tb/tb_bus_periph_responder.sv - directed self-checking bench for bus_periph_responder
module tb_bus_periph_responder;

  localparam logic [31:0] A_DIG   = 32'hFFFF_F000;
  localparam logic [31:0] A_TIMER = 32'hFFFF_F020;
  localparam logic [31:0] A_LED   = 32'hFFFF_F060;
  localparam logic [31:0] A_SW    = 32'hFFFF_F070;
  localparam logic [31:0] A_BTN   = 32'hFFFF_F078;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  we = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [23:0] sw = 24'h0;
  logic [4:0]  button = 5'h0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int total = 0;
  int bad = 0;

  bus_periph_responder #(.BASE_ADDR(32'hFFFF_F000), .SCAN_DIV(4), .TIMER_DIV(1)) dut (
    .cpu_clk(clk), .cpu_rst_n(rst_n), .Bus_addr(addr), .Bus_we(we),
    .Bus_wdata(wdata), .Bus_rdata(rdata), .sw(sw), .button(button),
    .led(led), .dig_en(dig_en), .dig_seg(dig_seg)
  );

  always #5 clk = ~clk;

  // Inputs set at a falling edge; the write lands on the next rising edge
  task automatic bus_write(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    addr = a; we = w; wdata = d;
    @(negedge clk);
    we = 4'h0;
    #1;
  endtask

  task automatic test_reset;
    addr = A_TIMER;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_timer got=%h exp=%h", rdata, 32'h0); end
    total++; if (led !== 24'h0) begin bad++; $display("FAIL reset_led got=%h exp=%h", led, 24'h0); end
    total++; if (dig_en !== 8'hFE) begin bad++; $display("FAIL reset_dig_en got=%h exp=%h", dig_en, 8'hFE); end
    total++; if (dig_seg !== 8'h3F) begin bad++; $display("FAIL reset_dig_seg got=%h exp=%h", dig_seg, 8'h3F); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total++; if (rdata !== 32'd1) begin bad++; $display("FAIL restart_timer1 got=%h exp=%h", rdata, 32'd1); end
    repeat (2) @(negedge clk);
    #1;
    total++; if (rdata !== 32'd3) begin bad++; $display("FAIL restart_timer3 got=%h exp=%h", rdata, 32'd3); end
  endtask

  task automatic test_led;
    addr = A_LED; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL led_init got=%h exp=%h", rdata, 32'h0); end
    bus_write(A_LED, 4'b0101, 32'hAABB_CCDD);
    total++; if (led !== 24'hBB00DD) begin bad++; $display("FAIL led_lanes got=%h exp=%h", led, 24'hBB00DD); end
    total++; if (rdata !== 32'h00BB_00DD) begin bad++; $display("FAIL led_read got=%h exp=%h", rdata, 32'h00BB_00DD); end
    bus_write(A_LED, 4'b1000, 32'h1122_3344);
    total++; if (led !== 24'hBB00DD) begin bad++; $display("FAIL led_lane3 got=%h exp=%h", led, 24'hBB00DD); end
  endtask

  task automatic test_sync;
    @(negedge clk);
    addr = A_SW; sw = 24'h123456;
    @(negedge clk); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL sw_edge_n got=%h exp=%h", rdata, 32'h0); end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h0012_3456) begin bad++; $display("FAIL sw_edge_n1 got=%h exp=%h", rdata, 32'h0012_3456); end
    addr = A_BTN; button = 5'h11;
    @(negedge clk); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL btn_edge_n got=%h exp=%h", rdata, 32'h0); end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h11) begin bad++; $display("FAIL btn_edge_n1 got=%h exp=%h", rdata, 32'h11); end
  endtask

  task automatic test_scan;
    logic [7:0]  seg_tbl [16];
    logic [31:0] dval;
    logic [3:0]  nib;
    seg_tbl = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    dval = 32'h89AB_CDEF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    addr = A_DIG; we = 4'hF; wdata = dval;
    @(negedge clk);
    we = 4'h0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) repeat (3) @(negedge clk);
      else if (i > 1) repeat (4) @(negedge clk);
      #1;
      nib = dval[4*i +: 4];
      total++;
      if (dig_en !== ~(8'b1 << i) || dig_seg !== seg_tbl[nib]) begin
        bad++;
        $display("FAIL scan_idx%0d got en=%h seg=%h exp en=%h seg=%h", i, dig_en, dig_seg, ~(8'b1 << i), seg_tbl[nib]);
      end
    end
    repeat (4) @(negedge clk);
    #1;
    total++; if (dig_en !== 8'hFE || dig_seg !== 8'h71) begin bad++; $display("FAIL scan_wrap got en=%h seg=%h exp en=fe seg=71", dig_en, dig_seg); end
  endtask

  task automatic test_timer;
    bus_write(A_TIMER, 4'hF, 32'hFFFF_FFFE);
    total++; if (rdata !== 32'hFFFF_FFFE) begin bad++; $display("FAIL timer_load got=%h exp=%h", rdata, 32'hFFFF_FFFE); end
    @(negedge clk); #1;
    total++; if (rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timer_max got=%h exp=%h", rdata, 32'hFFFF_FFFF); end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL timer_wrap got=%h exp=%h", rdata, 32'h0); end
    bus_write(A_TIMER, 4'hF, 32'h10);
    total++; if (rdata !== 32'h10) begin bad++; $display("FAIL timer_write_wins got=%h exp=%h", rdata, 32'h10); end
    @(negedge clk); #1;
    total++; if (rdata !== 32'h11) begin bad++; $display("FAIL timer_after_write got=%h exp=%h", rdata, 32'h11); end
  endtask

  task automatic test_decode;
    addr = 32'hFFFF_F100; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=%h", rdata, 32'h0); end
    bus_write(32'h0000_F060, 4'hF, 32'hFFFF_FFFF);
    total++; if (led !== 24'hBB00DD) begin bad++; $display("FAIL nohit_led got=%h exp=%h", led, 24'hBB00DD); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL nohit_read got=%h exp=%h", rdata, 32'h0); end
    bus_write(A_SW, 4'hF, 32'hFFFF_FFFF);
    total++; if (rdata !== 32'h0012_3456) begin bad++; $display("FAIL sw_readonly got=%h exp=%h", rdata, 32'h0012_3456); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_sync();
    test_decode();
    test_timer();
    test_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
